multicycle_control: RTL

- Multicycle control FSM sitting directly upstream of the datapath.
- Consumes the latched instruction's opcode/funct fields and a memory-ready handshake.
- Produces every datapath control strobe (clrPc, MemWrite, ALUSrc, RegWrite, selA/selB/selC, RegDSt, MemRead, MemtoReg, Signed, branch), plus PC/IR write enables and a fault code.
- Replaces the hand-driven control in the datapath bench.

---
 rtl/multicycle_control.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// Multicycle control FSM for the single-bus datapath.
// Decodes the latched instruction and sequences fetch/decode/exec/mem/wb.
module multicycle_control #(
    parameter int WAIT_LIMIT = 15
) (
    input  logic       clk,
    input  logic       clrPc_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       clrPc,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       ALUSrc,
    output logic       RegWrite,
    output logic       RegDSt,
    output logic       MemtoReg,
    output logic       Signed,
    output logic       branch,
    output logic       selA,
    output logic       selB,
    output logic       selC,
    output logic [1:0] fault
);

    typedef enum logic [2:0] {
        S_RST,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [7:0] CNT_LAST = 8'(WAIT_LIMIT - 1);

    state_t     r_state;
    state_t     w_next;
    logic [5:0] r_op;
    logic [5:0] r_funct;
    logic [1:0] r_fault;
    logic [1:0] w_fault_nxt;
    logic [7:0] r_cnt;

    logic       w_rtype;
    logic       w_addi;
    logic       w_andi;
    logic       w_ori;
    logic       w_lw;
    logic       w_sw;
    logic       w_beq;
    logic       w_isrc;
    logic       w_sext;
    logic [2:0] w_alu;
    logic       w_legal;
    logic       w_cnt_hit;

    assign w_rtype = (r_op == OP_R);
    assign w_addi  = (r_op == OP_ADDI);
    assign w_andi  = (r_op == OP_ANDI);
    assign w_ori   = (r_op == OP_ORI);
    assign w_lw    = (r_op == OP_LW);
    assign w_sw    = (r_op == OP_SW);
    assign w_beq   = (r_op == OP_BEQ);

    // Only legal opcodes ever reach EXEC, so the complement is safe here
    assign w_isrc = ~(w_rtype | w_beq);
    assign w_sext = w_addi | w_lw | w_sw;

    assign w_cnt_hit = (r_cnt == CNT_LAST);

    always_comb begin
        w_alu = 3'b000;
        unique case (1'b1)
            w_rtype: begin
                case (r_funct)
                    FN_SUB:  w_alu = 3'b001;
                    FN_AND:  w_alu = 3'b010;
                    FN_OR:   w_alu = 3'b011;
                    FN_SLT:  w_alu = 3'b100;
                    default: w_alu = 3'b000;
                endcase
            end
            w_andi:  w_alu = 3'b010;
            w_ori:   w_alu = 3'b011;
            w_beq:   w_alu = 3'b001;
            default: w_alu = 3'b000;
        endcase
    end

    always_comb begin
        w_legal = 1'b0;
        case (opcode)
            OP_R: begin
                w_legal = (funct == FN_ADD) || (funct == FN_SUB) ||
                          (funct == FN_AND) || (funct == FN_OR)  ||
                          (funct == FN_SLT);
            end
            OP_ADDI, OP_ANDI, OP_ORI,
            OP_LW, OP_SW, OP_BEQ: w_legal = 1'b1;
            default: w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_next      = r_state;
        w_fault_nxt = r_fault;
        unique case (r_state)
            S_RST: w_next = S_FETCH;
            S_FETCH: begin
                if (mem_ready) begin
                    w_next = S_DECODE;
                end else if (w_cnt_hit) begin
                    w_next      = S_HALT;
                    w_fault_nxt = 2'b10;
                end
            end
            S_DECODE: begin
                if (w_legal) begin
                    w_next = S_EXEC;
                end else begin
                    w_next      = S_HALT;
                    w_fault_nxt = 2'b01;
                end
            end
            S_EXEC: begin
                if (w_lw || w_sw) w_next = S_MEM;
                else if (w_beq)   w_next = S_FETCH;
                else              w_next = S_WB;
            end
            S_MEM: begin
                if (mem_ready) begin
                    w_next = w_lw ? S_WB : S_FETCH;
                end else if (w_cnt_hit) begin
                    w_next      = S_HALT;
                    w_fault_nxt = 2'b10;
                end
            end
            S_WB:   w_next = S_FETCH;
            S_HALT: w_next = S_HALT;
            default: w_next = S_RST;
        endcase
    end

    // Load enables qualify on mem_ready so PC advances once per fetch
    always_comb begin
        clrPc    = 1'b0;
        PCWrite  = 1'b0;
        IRWrite  = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        ALUSrc   = 1'b0;
        RegWrite = 1'b0;
        RegDSt   = 1'b0;
        MemtoReg = 1'b0;
        Signed   = 1'b0;
        branch   = 1'b0;
        selA     = 1'b0;
        selB     = 1'b0;
        selC     = 1'b0;
        unique case (r_state)
            S_RST: clrPc = 1'b1;
            S_FETCH: begin
                MemRead = 1'b1;
                PCWrite = mem_ready;
                IRWrite = mem_ready;
            end
            S_EXEC: begin
                ALUSrc             = w_isrc;
                Signed             = w_sext;
                branch             = w_beq;
                {selC, selB, selA} = w_alu;
            end
            S_MEM: begin
                MemRead            = w_lw;
                MemWrite           = w_sw;
                ALUSrc             = w_isrc;
                Signed             = w_sext;
                {selC, selB, selA} = w_alu;
            end
            S_WB: begin
                RegWrite           = 1'b1;
                RegDSt             = w_rtype;
                MemtoReg           = w_lw;
                ALUSrc             = w_isrc;
                Signed             = w_sext;
                {selC, selB, selA} = w_alu;
            end
            default: begin
            end
        endcase
    end

    assign fault = r_fault;

    always_ff @(posedge clk or negedge clrPc_n) begin
        if (!clrPc_n) begin
            r_state <= S_RST;
            r_op    <= 6'd0;
            r_funct <= 6'd0;
            r_fault <= 2'b00;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_next;
            r_fault <= w_fault_nxt;
            if (r_state == S_DECODE) begin
                r_op    <= opcode;
                r_funct <= funct;
            end
            if (w_next != r_state) begin
                r_cnt <= 8'd0;
            end else if (r_state == S_FETCH || r_state == S_MEM) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

endmodule
